// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a registered one-hot grant.
// Define RR_ARB_LOCK_EN to make grants sticky, bounded by MAX_HOLD cycles.
module rr_arbiter8 #(
    parameter int unsigned RESET_PTR = 0,
    parameter int unsigned MAX_HOLD  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic       gnt_valid
);

    if (RESET_PTR > 7 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
        $error("rr_arbiter8: RESET_PTR must be 0..7 and MAX_HOLD 1..255");
    end

    // Returns {found, index}: first set request scanning upward from p, wrapping 7 -> 0.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [7:0] gnt_q, gnt_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] pick;
    logic       keep;

`ifdef RR_ARB_LOCK_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

    always_comb begin
        pick        = rr_pick(req, ptr_q);
        keep        = 1'b0;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
`ifdef RR_ARB_LOCK_EN
        hold_cnt_d  = hold_cnt_q;
        // Holder still requesting and under its budget keeps the grant.
        keep = gnt_valid_q && (|(req & gnt_q)) && (hold_cnt_q < HOLD_LAST);
`endif
        if (en) begin
            if (keep) begin
`ifdef RR_ARB_LOCK_EN
                hold_cnt_d = hold_cnt_q + 8'd1;
`endif
            end else if (pick[3]) begin
                gnt_d       = 8'b1 << pick[2:0];
                gnt_valid_d = 1'b1;
                ptr_d       = pick[2:0] + 3'd1;
`ifdef RR_ARB_LOCK_EN
                hold_cnt_d  = 8'd0;
`endif
            end else begin
                gnt_d       = 8'h00;
                gnt_valid_d = 1'b0;
`ifdef RR_ARB_LOCK_EN
                hold_cnt_d  = 8'd0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= 8'h00;
            gnt_valid_q <= 1'b0;
            ptr_q       <= 3'(RESET_PTR);
`ifdef RR_ARB_LOCK_EN
            hold_cnt_q  <= 8'd0;
`endif
        end else begin
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
`ifdef RR_ARB_LOCK_EN
            hold_cnt_q  <= hold_cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;

endmodule
